// File: rtl/rca_ctrl_pkg.sv
// Shared constants for the RCA32 sharing arbiter: state encoding, default
// sizing and the settle-counter width.
package rca_ctrl_pkg;

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int CNT_W             = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/rca32.sv
// Plain combinational ripple-carry adder; the carry chain runs through every
// bit, which is why it is only ever sampled after a multi-cycle settle.
module RCA32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryInput,
  output logic [WIDTH-1:0] sum,
  output logic             carryOutput
);

  logic [WIDTH:0] carry;

  assign carry[0] = carryInput;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carryOutput = carry[WIDTH];

endmodule

// File: rtl/rca32_share_arbiter.sv
// Round-robin sharing of one RCA32 between two requesters. Operands are held
// at the adder for SETTLE_CYCLES (1..15) before the sum is captured.
module rca32_share_arbiter
  import rca_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  input  logic             res_ready,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;
  logic             last_grant_q, last_grant_d;

  logic             grant_sel;
  logic             xfer;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  RCA32 #(.WIDTH(WIDTH)) u_rca (
    .a           (op_a_q),
    .b           (op_b_q),
    .carryInput  (op_cin_q),
    .sum         (add_sum),
    .carryOutput (add_cout)
  );

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    if (req0_valid && req1_valid) grant_sel = ~last_grant_q;
    else if (req1_valid)          grant_sel = 1'b1;
    else                          grant_sel = 1'b0;
  end

  // Readies are gated by rst directly so they drop the moment reset rises.
  assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && !grant_sel;
  assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid &&  grant_sel;
  assign xfer       = req0_ready || req1_ready;

  // NOTE: every next-state signal gets a default hold value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_cin_d     = op_cin_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          op_a_d       = grant_sel ? req1_a   : req0_a;
          op_b_d       = grant_sel ? req1_b   : req0_b;
          op_cin_d     = grant_sel ? req1_cin : req0_cin;
          res_id_d     = grant_sel;
          last_grant_d = grant_sel;
          cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          res_sum_d   = add_sum;
          res_cout_d  = add_cout;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_cin_q     <= op_cin_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rca32_share_arbiter.sv
// Directed bench for rca32_share_arbiter: a SETTLE_CYCLES=2 instance for the
// functional cases and a SETTLE_CYCLES=1 instance for issue-interval timing.
module tb_rca32_share_arbiter;

  localparam int W = 32;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_cin, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_id, res_cout, res_ready, busy;
  logic [W-1:0] res_sum;

  logic         b_req0_valid, b_req0_ready, b_req1_ready;
  logic [W-1:0] b_req0_a, b_req0_b, b_res_sum;
  logic         b_res_valid, b_res_id, b_res_cout, b_busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rca32_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .res_cout(res_cout), .res_ready(res_ready), .busy(busy)
  );

  rca32_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_a(b_req0_a), .req0_b(b_req0_b),
    .req0_cin(1'b0), .req0_ready(b_req0_ready),
    .req1_valid(1'b0), .req1_a('0), .req1_b('0),
    .req1_cin(1'b0), .req1_ready(b_req1_ready),
    .res_valid(b_res_valid), .res_id(b_res_id), .res_sum(b_res_sum),
    .res_cout(b_res_cout), .res_ready(1'b1), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Call at a negedge with valids already driven. Waits for a grant, checks
  // who got it, then checks result latency and contents.
  task automatic run_op(input string tag, input logic exp_id, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input bit drop);
    int  n;
    bit  got;
    int  edges;
    logic gid;
    n = 0; got = 0;
    #1;
    while (n < 30) begin
      if (req0_ready || req1_ready) begin got = 1; break; end
      @(negedge clk); #1;
      n++;
    end
    check({tag, " grant_seen"}, 64'(got), 64'd1);
    if (!got) return;
    check({tag, " one_ready"}, 64'(req0_ready & req1_ready), 64'd0);
    gid = req1_ready;
    check({tag, " grant_id"}, 64'(gid), 64'(exp_id));
    @(posedge clk);
    @(negedge clk);
    if (drop) begin
      if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
    end
    #1;
    check({tag, " ready_drops"}, 64'(req0_ready | req1_ready), 64'd0);
    edges = 0;
    while (edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (res_valid) break;
    end
    check({tag, " latency"}, 64'(edges), 64'(S));
    check({tag, " sum"}, 64'(res_sum), 64'(exp_sum));
    check({tag, " cout"}, 64'(res_cout), 64'(exp_cout));
    check({tag, " id"}, 64'(res_id), 64'(exp_id));
  endtask

  initial begin
    int first_x, second_x, cyc, seen_valid;

    rst = 1'b1;
    res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd23632145; req0_b = 32'd29946753; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1915427;  req1_b = 32'd9538849;  req1_cin = 1'b0;
    b_req0_valid = 1'b0; b_req0_a = '0; b_req0_b = '0;

    // Reset state with both valids asserted.
    repeat (2) @(negedge clk);
    #1;
    check("rst ready0", 64'(req0_ready), 64'd0);
    check("rst ready1", 64'(req1_ready), 64'd0);
    check("rst res_valid", 64'(res_valid), 64'd0);
    check("rst res_sum", 64'(res_sum), 64'd0);
    check("rst res_id", 64'(res_id), 64'd0);
    check("rst busy", 64'(busy), 64'd0);

    // Simultaneous requests: alternation 0,1,0,1.
    @(negedge clk);
    rst = 1'b0;
    run_op("tie0", 1'b0, 32'd53578898, 1'b0, 1'b0);
    run_op("tie1", 1'b1, 32'd11454276, 1'b0, 1'b0);
    run_op("tie2", 1'b0, 32'd53578898, 1'b0, 1'b0);
    run_op("tie3", 1'b1, 32'd11454276, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Single request from requester 0.
    req0_valid = 1'b1; req0_a = 32'd2212768; req0_b = 32'd3612427; req0_cin = 1'b0;
    run_op("single", 1'b0, 32'd5825195, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Carry-in and overflow on requester 1.
    req1_valid = 1'b1; req1_a = 32'd4519087; req1_b = 32'd326432; req1_cin = 1'b1;
    run_op("cin", 1'b1, 32'd4845520, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_cin = 1'b0;
    run_op("ovf", 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // Backpressure: result held while res_ready is low.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd32768; req0_b = 32'd32768; req0_cin = 1'b0;
    run_op("bp", 1'b0, 32'd65536, 1'b0, 1'b1);
    req0_valid = 1'b1; req0_a = 32'd23632145; req0_b = 32'd29946753;
    req1_valid = 1'b1; req1_a = 32'd1915427;  req1_b = 32'd9538849; req1_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp hold valid", 64'(res_valid), 64'd1);
      check("bp hold sum", 64'(res_sum), 64'd65536);
      check("bp hold id", 64'(res_id), 64'd0);
      check("bp readies", 64'({req0_ready, req1_ready}), 64'd0);
      check("bp busy", 64'(busy), 64'd1);
    end
    res_ready = 1'b1;
    run_op("bp next", 1'b1, 32'd11454276, 1'b0, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of SETTLE.
    req0_valid = 1'b1; req0_a = 32'd1000; req0_b = 32'd2000; req0_cin = 1'b0;
    #1;
    check("rs grant", 64'(req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rs in settle", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rs busy", 64'(busy), 64'd0);
    check("rs ready0", 64'(req0_ready), 64'd0);
    check("rs res_valid", 64'(res_valid), 64'd0);
    check("rs res_sum", 64'(res_sum), 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (res_valid) seen_valid = 1;
    end
    check("rs no result", 64'(seen_valid), 64'd0);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd655355467; req0_b = 32'd655354378; req0_cin = 1'b0;
    run_op("rs after", 1'b0, 32'd1310709845, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // SETTLE_CYCLES=1 instance: back-to-back issue interval.
    b_req0_valid = 1'b1; b_req0_a = 32'd7; b_req0_b = 32'd8;
    first_x = -1; second_x = -1; cyc = 0;
    while (cyc < 20 && second_x < 0) begin
      #1;
      if (b_req0_ready) begin
        if (first_x < 0) first_x = cyc; else second_x = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    b_req0_valid = 1'b0;
    check("s1 interval", 64'(second_x - first_x), 64'd3);
    check("s1 sum", 64'(b_res_sum), 64'd15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rca32_share_arbiter.md
Name: rca32_share_arbiter

Overview:
Shares one RCA32 ripple-carry adder instance between two requesters. Arbitration is round-robin. Each requester uses a valid/ready operand handshake. Once an operation is granted, the block holds the operands stable at the adder for a programmable settle time, captures the sum and carry-out into registers, and presents them on a single result channel tagged with the requester ID. It sits between the operand sources and the combinational adder, so the ripple delay is never on a single-cycle path.

Parameters:
WIDTH, 32, operand/sum width; must match the RCA32 width.
SETTLE_CYCLES, 2, cycles operands are held at the adder before capture; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 operands valid
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req0_cin  in  1  requester 0 carry-in
req0_ready  out  1  requester 0 operands accepted this cycle
req1_valid / req1_a / req1_b / req1_cin / req1_ready  same as requester 0, for requester 1
res_valid  out  1  result channel valid
res_id  out  1  requester the result belongs to (0/1)
res_sum  out  WIDTH  captured adder sum
res_cout  out  1  captured adder carry-out
res_ready  in  1  result consumer accepts the result
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous, active-high. While rst is high: state=IDLE, op_a=op_b=0, op_cin=0, res_valid=0, res_id=0, res_sum=0, res_cout=0, last_grant=1 (so requester 0 wins the first tie), settle counter=0. Both reqN_ready outputs are forced to 0 while rst is asserted.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - grant_sel is combinational. If only one valid is high, grant that requester. If both are high, grant ~last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && (grant_sel==N). At most one ready is high in any cycle.
  - On a clock edge with a transfer: latch a/b/cin into op regs, set res_id=N and last_grant=N, load cnt=SETTLE_CYCLES-1, go to SETTLE.
  - No valid: stay in IDLE.
- SETTLE:
  - The op regs drive RCA32 continuously.
  - cnt!=0: decrement.
  - cnt==0: capture res_sum<=sum and res_cout<=carryOutput, set res_valid<=1, go to DONE.
- DONE:
  - res_valid=1. res_id, res_sum and res_cout are held stable until the handshake.
  - res_valid && res_ready: clear res_valid and go to IDLE. A new grant happens no earlier than the following cycle.
  - No ready is asserted in SETTLE or DONE.
- Timing:
  - Transfer at edge T gives res_valid high after edge T+SETTLE_CYCLES.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles (zero-wait res_ready).
- Requester rules:
  - Requesters hold valid and operands until they see ready.
  - Dropping valid before ready is legal and has no effect.
  - Operand changes after acceptance are ignored.
- Arithmetic is modulo 2^WIDTH; overflow appears only in res_cout. Example: all-ones + all-ones + 0 gives sum 0xFFFFFFFE, cout 1.
- A requester that holds valid continuously loses every tie to the other requester alternately. No starvation: a pending requester is served within one intervening operation.
- Reset mid-operation (SETTLE or DONE) abandons the operation. No result is produced, and last_grant returns to 1.

Decomposition:
- Shared package rca_ctrl_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_DONE=2'd2
  - the default WIDTH and SETTLE_CYCLES values
  - the counter width constant (4 bits)
- Single sub-module: the existing RCA32, instantiated once. Its a, b and carryInput are driven from the op regs; its sum and carryOutput feed the capture regs.
- Arbitration is inline; no separate arbiter module.

Test Plan:
- Single request: req0 a=2212768, b=3612427, cin=0, res_ready=1 -> req0_ready for 1 cycle; res_valid exactly SETTLE_CYCLES edges later with res_sum=5825195, res_cout=0, res_id=0.
- Carry-in and overflow: req1 a=4519087, b=326432, cin=1 -> res_sum=4845520, res_id=1. Then req1 a=b=4294967295, cin=0 -> res_sum=4294967294, res_cout=1.
- Simultaneous request after reset: req0 (23632145+29946753) and req1 (1915427+9538849) both valid from cycle 0 -> req0 served first with res_sum=53578898, then req1 with res_sum=11454276, res_id 0 then 1. Both held valid for 4 ops -> grants alternate 0,1,0,1.
- Backpressure: result ready for 32768+32768, res_ready held low for 5 cycles -> res_valid, res_sum=65536 and res_id stay stable; both readies stay 0 with both valids high; busy=1. Raising res_ready completes the handshake and the next grant follows.
- Reset in SETTLE: pulse rst asynchronously mid-settle -> all outputs 0 immediately, no res_valid afterwards for the abandoned op; a subsequent req0 of 655355467+655354378 returns 1310709845.
- SETTLE_CYCLES=1 build: back-to-back req0 ops with res_ready=1 -> issue interval measured as 3 cycles.
